// File: rtl/muldiv_ctrl.sv
// Iterative multu/divu unit with architectural HI/LO registers and pipeline stall request.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divu completes at once with HI=LO=0.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] hi_prev, lo_prev;
  logic [WIDTH:0]   mul_sum;
  logic             accept, issue, bypass, commit, restore, div_bypass;

`ifdef MULDIV_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_shift;
  logic             rem_lt;
  assign div_bypass = 1'b0;
`else
  assign div_bypass = op_div;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = div_bypass ? DONE : RUN;
      RUN: begin
        if (abort)                state_nxt = IDLE;
        else if (cnt == LAST_CNT) state_nxt = DONE;
      end
      DONE: begin
        if (abort)      state_nxt = IDLE;
        else if (start) state_nxt = div_bypass ? DONE : RUN;
        else            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new operation is accepted from IDLE, or from DONE unless it is being cancelled.
  assign accept  = start & ((state == IDLE) | ((state == DONE) & ~abort));
  assign issue   = accept & ~div_bypass;
  assign bypass  = accept & div_bypass;
  assign commit  = (state == RUN) & ~abort & (cnt == LAST_CNT);
  assign restore = (state == DONE) & abort;

  assign busy  = (state != IDLE);
  assign stall = (state == RUN) & (hilo_rd | start);
  assign done  = (state == DONE) & ~abort;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // With a zero divisor every trial subtract succeeds: quotient all ones, remainder = dividend.
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    rem_lt    = rem_shift < {1'b0, opnd};
    if (div_q) begin
      step_hi = rem_lt ? rem_shift[WIDTH-1:0] : rem_shift[WIDTH-1:0] - opnd;
      step_lo = {acc_lo[WIDTH-2:0], ~rem_lt};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi      <= '0;
      lo      <= '0;
      hi_prev <= '0;
      lo_prev <= '0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      if (issue) begin
        cnt    <= '0;
        acc_hi <= '0;
`ifdef MULDIV_DIV_EN
        div_q  <= op_div;
        opnd   <= op_div ? op_b : op_a;
        acc_lo <= op_div ? op_a : op_b;
`else
        opnd   <= op_a;
        acc_lo <= op_b;
`endif
      end else if (state == RUN) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end

      // hi_prev/lo_prev let a cancel during DONE roll HI/LO back to their pre-operation values.
      if (commit | bypass) begin
        hi_prev <= hi;
        lo_prev <= lo;
        hi      <= bypass ? '0 : step_hi;
        lo      <= bypass ? '0 : step_lo;
      end else if (restore) begin
        hi <= hi_prev;
        lo <= lo_prev;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO and completion cycle are queued at issue and
// checked by a monitor on every done pulse. Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_ctrl;
  localparam int WIDTH    = 32;
  localparam int ITER_LAT = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    int               due;
  } exp_t;

  logic             clk = 1'b0, rst = 1'b0, start = 1'b0, op_div = 1'b0;
  logic             hilo_rd = 1'b0, abort = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic             busy, stall, done;
  logic [WIDTH-1:0] hi, lo;

  int               cyc = 0;
  int               n_vec = 0;
  int               n_bad = 0;
  exp_t             sb[$];
  logic [WIDTH-1:0] model_hi = '0, model_lo = '0;

  muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .op_a(op_a), .op_b(op_b),
    .hilo_rd(hilo_rd), .abort(abort), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result straight from the arithmetic definition of multu/divu.
  function automatic exp_t model(input bit div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [2*WIDTH-1:0] p;
    e.due = ITER_LAT;
    if (!div) begin
      p    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      e.hi = p[2*WIDTH-1:WIDTH];
      e.lo = p[WIDTH-1:0];
    end else begin
`ifdef MULDIV_DIV_EN
      if (b == '0) begin
        e.hi = a;
        e.lo = '1;
      end else begin
        e.hi = a % b;
        e.lo = a / b;
      end
`else
      e.hi  = '0;
      e.lo  = '0;
      e.due = 1;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.due));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  // Called at a falling edge; start is sampled on the next rising edge. Returns one falling edge later.
  task automatic issue(input bit div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit expect_done, input bit hold);
    exp_t e;
    start  = 1'b1;
    op_div = div;
    op_a   = a;
    op_b   = b;
    if (expect_done) begin
      e     = model(div, a, b);
      e.due = cyc + e.due;
      sb.push_back(e);
      model_hi = e.hi;
      model_lo = e.lo;
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: %0d result(s) still outstanding (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] a, b, a2, b2, prev_hi, prev_lo;
    exp_t             e;
    bit               div;

    #3;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
    wait_done(60);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(60);
    issue(1'b1, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_done(60);
    issue(1'b1, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0);
    wait_done(60);

    // mfhi/mflo held from cycle 5 of a multu: stalls through RUN, released on the completion cycle.
    issue(1'b0, 32'h0001_0003, 32'h0000_0101, 1'b1, 1'b0);
    for (int n = 1; n <= WIDTH + 1; n++) begin
      if (n >= 5) check($sformatf("stall_hilo_c%0d", n), 64'(stall), 64'(n <= WIDTH));
      if (n == 4) hilo_rd = 1'b1;
      if (n <= WIDTH) @(negedge clk);
    end
    check("hilo_rd_hi", 64'(hi), 64'(model_hi));
    check("hilo_rd_lo", 64'(lo), 64'(model_lo));
    hilo_rd = 1'b0;
    wait_done(10);

    // Cancel in cycle 10 of RUN.
    prev_hi = model_hi;
    prev_lo = model_lo;
    issue(1'b0, $urandom, $urandom, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_run_busy", 64'(busy), 64'(0));
    check("abort_run_hi", 64'(hi), 64'(prev_hi));
    check("abort_run_lo", 64'(lo), 64'(prev_lo));
    repeat (WIDTH + 4) @(negedge clk);

    // Cancel during the completion cycle: no done pulse, HI/LO roll back.
    issue(1'b0, 32'h89AB_CDEF, 32'h1357_9BDF, 1'b0, 1'b0);
    repeat (WIDTH - 1) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_done_pulse", 64'(done), 64'(0));
    check("abort_done_stall", 64'(stall), 64'(0));
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_done_busy", 64'(busy), 64'(0));
    check("abort_done_hi", 64'(hi), 64'(prev_hi));
    check("abort_done_lo", 64'(lo), 64'(prev_lo));

    // Reset asserted mid-cycle during RUN clears everything without waiting for a clock edge.
    issue(1'b0, $urandom, $urandom, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_run_hi", 64'(hi), 64'(0));
    check("rst_run_lo", 64'(lo), 64'(0));
    check("rst_run_busy", 64'(busy), 64'(0));
    check("rst_run_stall", 64'(stall), 64'(0));
    check("rst_run_done", 64'(done), 64'(0));
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'd7, 32'd6, 1'b1, 1'b0);
    wait_done(60);

    // start held through RUN is ignored (stalled) and re-issues from DONE back-to-back.
    a2 = $urandom;
    b2 = $urandom;
    issue(1'b0, $urandom, $urandom, 1'b1, 1'b1);
    op_a = a2;
    op_b = b2;
    for (int n = 1; n <= WIDTH; n++) begin
      check($sformatf("stall_start_c%0d", n), 64'(stall), 64'(1));
      if (n == WIDTH) begin
        e     = model(1'b0, a2, b2);
        e.due = cyc + 1 + e.due;
        sb.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
      end
      @(negedge clk);
    end
    check("stall_in_done", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0;
    wait_done(60);

    for (int i = 0; i < 40; i++) begin
      div = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = WIDTH'($urandom_range(1, 15));
        2:       a = '1;
        default: ;
      endcase
      hilo_rd = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(div, a, b, 1'b1, 1'b0);
      wait_done(60);
      hilo_rd = 1'b0;
    end
    check("final_busy", 64'(busy), 64'(0));
    check("final_hi", 64'(hi), 64'(model_hi));
    check("final_lo", 64'(lo), 64'(model_lo));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
